imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 122 ++++++++++++
 tb/tb_imem_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checksummed byte stream into instruction memory.
module imem_loader #(
    parameter int          DEPTH = 16,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        WE,
    output logic [31:0] WA,
    output logic [31:0] WD,
    output logic        cpu_reset,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE} state_t;
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);
    state_t      state, state_n;
    logic [4:0]  idx, idx_n, n, n_n;
    logic [1:0]  bidx, bidx_n;
    logic [7:0]  csum, csum_n;
    logic [31:0] word, word_n, word_nx, wa_n, wd_n;
    logic        acc, rdy_n, we_n, cpu_reset_n, done_n, err_n;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            n         <= '0;
            bidx      <= '0;
            csum      <= '0;
            word      <= '0;
            rx_ready  <= 1'b0;
            WE        <= 1'b0;
            WA        <= '0;
            WD        <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            n         <= n_n;
            bidx      <= bidx_n;
            csum      <= csum_n;
            word      <= word_n;
            rx_ready  <= rdy_n;
            WE        <= we_n;
            WA        <= wa_n;
            WD        <= wd_n;
            cpu_reset <= cpu_reset_n;
            done      <= done_n;
            err       <= err_n;
        end
    end
    // rx_ready is registered, so it already reflects the current state
    assign acc     = rx_valid && rx_ready;
    assign word_nx = {rx_data, word[31:8]};
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        n_n         = n;
        bidx_n      = bidx;
        csum_n      = csum;
        word_n      = word;
        we_n        = 1'b0;
        wa_n        = WA;
        wd_n        = WD;
        cpu_reset_n = cpu_reset;
        done_n      = done;
        err_n       = err;
        if (start) begin
            state_n     = COUNT;
            idx_n       = '0;
            bidx_n      = '0;
            csum_n      = '0;
            cpu_reset_n = 1'b1;
            done_n      = 1'b0;
            err_n       = 1'b0;
        end else begin
            case (state)
                IDLE: cpu_reset_n = 1'b1;
                COUNT: if (acc) begin
                    if (rx_data != 8'd0 && rx_data <= DEPTH8) begin
                        state_n = DATA;
                        n_n     = rx_data[4:0];
                        csum_n  = rx_data;
                    end else begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end
                end
                DATA: if (acc) begin
                    csum_n = csum ^ rx_data;
                    word_n = word_nx;
                    bidx_n = bidx + 2'd1;
                    if (bidx == 2'd3) begin
                        we_n  = 1'b1;
                        wa_n  = BASE + {25'd0, idx, 2'b00};
                        wd_n  = word_nx;
                        idx_n = idx + 5'd1;
                        if (idx + 5'd1 == n) state_n = CHECK;
                    end
                end
                CHECK: if (acc) begin
                    if (rx_data == csum) begin
                        state_n     = DONE;
                        done_n      = 1'b1;
                        cpu_reset_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        rdy_n = state_n == COUNT || state_n == DATA || state_n == CHECK;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the imem_loader byte protocol, write pulses and reset.
module tb_imem_loader;
    logic        clk = 1'b0, clk_en = 1'b0;
    logic        reset = 1'b0, start = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, WE, cpu_reset, done, err;
    logic [31:0] WA, WD;
    int          n_checks = 0, n_fail = 0;
    logic [31:0] q_wa[$], q_wd[$];
    logic [7:0]  prog[12] = '{8'h31, 8'h20, 8'hA0, 8'hE3, 8'hE6, 8'h30, 8'hA0, 8'hE3,
                              8'h03, 8'h20, 8'h22, 8'hE0};
    logic [31:0] exp_w[3] = '{32'hE3A02031, 32'hE3A030E6, 32'hE0222003};

    imem_loader #(.DEPTH(16), .BASE(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .WE(WE), .WA(WA), .WD(WD), .cpu_reset(cpu_reset),
        .done(done), .err(err)
    );

    always #5 clk = clk_en ? ~clk : clk;

    always @(negedge clk) if (WE === 1'b1) begin
        q_wa.push_back(WA);
        q_wd.push_back(WD);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit rnd);
        int guard = 0;
        if (rnd) repeat ($urandom_range(0, 2)) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("rx_ready_timeout", 32'(guard), 32'd0);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_q();
        q_wa.delete();
        q_wd.delete();
    endtask

    task automatic load35(input logic [7:0] last, input bit rnd);
        send(8'h03, rnd);
        for (int i = 0; i < 12; i++) send(prog[i], rnd);
        send(last, rnd);
        @(posedge clk); #1;
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, 32'(q_wa.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_wa"}, q_wa[i], 32'(4 * i));
            chk({tag, "_wd"}, q_wd[i], exp_w[i]);
        end
    endtask

    initial begin
        // asynchronous reset with the clock stopped
        #1 reset = 1'b1;
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_wa", WA, 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("idle_rx_ready", 32'(rx_ready), 32'd0);
        chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);

        // good three-word load
        clear_q();
        pulse_start();
        chk("cnt_rx_ready", 32'(rx_ready), 32'd1);
        load35(8'h25, 1'b0);
        chk_writes("good");
        chk("good_done", 32'(done), 32'd1);
        chk("good_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("good_err", 32'(err), 32'd0);
        chk("good_rx_ready", 32'(rx_ready), 32'd0);

        // bad checksum
        clear_q();
        pulse_start();
        chk("restart_done", 32'(done), 32'd0);
        load35(8'h24, 1'b0);
        chk_writes("badck");
        chk("badck_err", 32'(err), 32'd1);
        chk("badck_done", 32'(done), 32'd0);
        chk("badck_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("badck_rx_ready", 32'(rx_ready), 32'd0);

        // N = 0 and N > DEPTH
        clear_q();
        pulse_start();
        chk("start_clears_err", 32'(err), 32'd0);
        send(8'h00, 1'b0);
        repeat (2) @(posedge clk); #1;
        chk("n0_err", 32'(err), 32'd1);
        chk("n0_rx_ready", 32'(rx_ready), 32'd0);
        chk("n0_nwr", 32'(q_wa.size()), 32'd0);
        pulse_start();
        send(8'h11, 1'b0);
        repeat (2) @(posedge clk); #1;
        chk("n17_err", 32'(err), 32'd1);
        chk("n17_rx_ready", 32'(rx_ready), 32'd0);
        chk("n17_nwr", 32'(q_wa.size()), 32'd0);

        // restart discards a partial word
        clear_q();
        pulse_start();
        send(8'h01, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h45, 1'b0);
        @(posedge clk); #1;
        chk("restart_nwr", 32'(q_wa.size()), 32'd1);
        chk("restart_wa", q_wa[0], 32'h0);
        chk("restart_wd", q_wd[0], 32'h44332211);
        chk("restart_done2", 32'(done), 32'd1);

        // random valid gaps, reset pulsed mid-DATA, then rerun
        clear_q();
        pulse_start();
        send(8'h03, 1'b1);
        for (int i = 0; i < 6; i++) send(prog[i], 1'b1);
        chk("pre_rst_nwr", 32'(q_wa.size()), 32'd1);
        clear_q();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_we", 32'(WE), 32'd0);
        chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_rst_wa", WA, 32'd0);
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("post_rst_nwr", 32'(q_wa.size()), 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);
        pulse_start();
        load35(8'h25, 1'b1);
        chk_writes("rerun");
        chk("rerun_done", 32'(done), 32'd1);
        chk("rerun_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("rerun_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
